led_matrix_scanner: RTL and testbench

Row-multiplexing driver for the 8x8 LED matrix, directly downstream of the game engine. It samples the engine's 8-row line display once per frame into a shadow buffer, so frames never tear. It then drives one row at a time: a blanking gap followed by a dwell period for each row. Its outputs go straight to the matrix row-select and column pins.

---
 rtl/led_matrix_scanner.sv | 131 +++++++++++++
 tb/tb_led_matrix_scanner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//
// Row-multiplexing driver for an 8x8 LED matrix. Once per frame, the
// 64-bit line display is copied into a shadow buffer. The copy is made
// while row 0 is blanked, so a frame that is being shown is never
// torn. Each row is then blanked for BLANK_CYCLES and driven for
// DWELL_CYCLES, from the bottom row (0) to the top row (7).
//
// State table:
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | all row/column pins inactive; on the last cycle of row 0
//            | the shadow buffer is loaded
//   ST_DRIVE | row rowIdx selected, columns show shadow[rowIdx]
//
// Ports:
//   clk        in   system clock, rising edge
//   rstBtn     in   synchronous active-high reset
//   frameIn    in   packed display; row r = frameIn[8r+7:8r], bit 7 = leftmost
//   rowSel     out  row select, one row active during DRIVE (polarity param)
//   colData    out  column drive for the selected row (polarity param)
//   rowIdx     out  row currently being blanked or driven
//   frameStart out  one-cycle pulse on the first DRIVE cycle of row 0
//
// Every output is decoded from registers only. frameIn reaches only
// the shadow buffer.

module led_matrix_scanner #(
    parameter int DWELL_CYCLES   = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rstBtn,
    input  logic [63:0] frameIn,
    output logic [7:0]  rowSel,
    output logic [7:0]  colData,
    output logic [2:0]  rowIdx,
    output logic        frameStart
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       row_n;
    logic             frame_start_n;
    logic             shadow_load;
    logic [7:0]       shadow [8];

    always_ff @(posedge clk) begin
        if (rstBtn) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            rowIdx     <= 3'd0;
            frameStart <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                shadow[r] <= 8'h00;
            end
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rowIdx     <= row_n;
            frameStart <= frame_start_n;
            if (shadow_load) begin
                for (int r = 0; r < 8; r++) begin
                    shadow[r] <= frameIn[8*r +: 8];
                end
            end
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt + 1'b1;
        row_n         = rowIdx;
        shadow_load   = 1'b0;
        frame_start_n = 1'b0;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = ST_DRIVE;
                    cnt_n   = '0;
                    // The shadow buffer is loaded only while row 0 is blanked.
                    // The matrix is dark at that moment, so a frame is never
                    // shown as a mix of old and new rows.
                    if (rowIdx == 3'd0) begin
                        shadow_load   = 1'b1;
                        frame_start_n = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt == DWELL_LAST) begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    row_n   = rowIdx + 3'd1;
                end
            end
            default: begin
                state_n = ST_BLANK;
                cnt_n   = '0;
            end
        endcase
    end

    logic [7:0] row_onehot;
    logic [7:0] col_lit;

    always_comb begin
        row_onehot = 8'h00;
        col_lit    = 8'h00;
        if (state == ST_DRIVE) begin
            row_onehot = 8'd1 << rowIdx;
            col_lit    = shadow[rowIdx];
        end
    end

    assign rowSel  = ROW_ACTIVE_LOW ? ~row_onehot : row_onehot;
    assign colData = COL_ACTIVE_LOW ? ~col_lit    : col_lit;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Testbench for led_matrix_scanner. It uses DWELL=4 and BLANK=2, which
// gives a 48-clock frame. dut_a uses the default polarity and dut_b uses
// the inverted polarity; both share the clock, reset and frame input.
// Expected per-cycle outputs come from a cycle-position model. They are
// queued before each scenario runs and popped as each cycle is sampled
// on the falling edge.

module tb_led_matrix_scanner;

    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rstBtn = 1'b1;
    logic [63:0] frameIn = 64'h0;

    logic [7:0] rowSel_a, colData_a, rowSel_b, colData_b;
    logic [2:0] rowIdx_a, rowIdx_b;
    logic       frameStart_a, frameStart_b;

    int checks = 0;
    int failures = 0;

    logic [19:0] q[$];

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK),
        .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b0)
    ) dut_a (
        .clk(clk), .rstBtn(rstBtn), .frameIn(frameIn),
        .rowSel(rowSel_a), .colData(colData_a),
        .rowIdx(rowIdx_a), .frameStart(frameStart_a)
    );

    led_matrix_scanner #(
        .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK),
        .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk(clk), .rstBtn(rstBtn), .frameIn(frameIn),
        .rowSel(rowSel_b), .colData(colData_b),
        .rowIdx(rowIdx_b), .frameStart(frameStart_b)
    );

    // Expected {rowSel, colData, rowIdx, frameStart} for cycle c after reset
    // release, given the frame that the shadow buffer holds at that cycle.
    function automatic logic [19:0] model(int c, logic [63:0] f, bit row_low, bit col_low);
        int slot, row;
        bit drv;
        logic [7:0] rs, cd;
        slot = c % FRAME;
        row  = slot / SLOT;
        drv  = (slot % SLOT) >= BLANK;
        rs   = drv ? (8'd1 << row) : 8'd0;
        cd   = drv ? f[8*row +: 8] : 8'd0;
        if (row_low) rs = ~rs;
        if (col_low) cd = ~cd;
        return {rs, cd, 3'(row), slot == BLANK};
    endfunction

    // Holds reset for 3 cycles. It returns at the sample point of cycle 0.
    task automatic do_reset(input logic [63:0] f);
        frameIn = f;
        rstBtn  = 1'b1;
        repeat (3) @(negedge clk);
        rstBtn  = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] got, exp;
        frameIn = {$urandom, $urandom};
        rstBtn  = 1'b1;
        for (int i = 0; i < 3; i++) q.push_back({8'hFF, 8'h00, 3'd0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = q.pop_front();
            got = {rowSel_a, colData_a, rowIdx_a, frameStart_a};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset i=%0d got=%h exp=%h", i, got, exp);
            end
        end
        rstBtn = 1'b0;
        exp = q.size() == 0 ? {8'hFF, 8'h00, 3'd0, 1'b0} : 20'h0;
        got = {rowSel_a, colData_a, rowIdx_a, frameStart_a};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_cycle0 got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_basic();
        logic [19:0] got, exp;
        logic [63:0] f;
        f = 64'h80;
        do_reset(f);
        for (int c = 0; c < 12; c++) q.push_back(model(c, f, 1'b1, 1'b0));
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            exp = q.pop_front();
            got = {rowSel_a, colData_a, rowIdx_a, frameStart_a};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL basic c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_tear();
        logic [19:0] got, exp;
        logic [63:0] f_old, f_new;
        f_old = {$urandom, $urandom};
        f_old[7:0] = 8'h80;
        f_new = f_old;
        f_new[7:0] = 8'h40;
        do_reset(f_old);
        // The second frame is loaded on the edge that ends cycle FRAME+1.
        for (int c = 0; c < FRAME + 8; c++)
            q.push_back(model(c, (c > FRAME + 1) ? f_new : f_old, 1'b1, 1'b0));
        for (int c = 0; c < FRAME + 8; c++) begin
            if (c > 0) @(negedge clk);
            exp = q.pop_front();
            got = {rowSel_a, colData_a, rowIdx_a, frameStart_a};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL tear c=%0d got=%h exp=%h", c, got, exp);
            end
            if (c == 20) frameIn = f_new;
        end
    endtask

    task automatic test_wrap();
        logic [19:0] got, exp;
        logic [63:0] f;
        int pulses, first, second;
        f = {$urandom, $urandom};
        pulses = 0; first = -1; second = -1;
        do_reset(f);
        for (int c = 0; c < 2 * FRAME; c++) q.push_back(model(c, f, 1'b1, 1'b0));
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c > 0) @(negedge clk);
            exp = q.pop_front();
            got = {rowSel_a, colData_a, rowIdx_a, frameStart_a};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL wrap c=%0d got=%h exp=%h", c, got, exp);
            end
            if (frameStart_a === 1'b1) begin
                pulses++;
                if (first < 0) first = c; else if (second < 0) second = c;
            end
        end
        checks++;
        if (pulses !== 2) begin
            failures++;
            $display("FAIL wrap_pulse_count got=%0d exp=2", pulses);
        end
        checks++;
        if (second - first !== FRAME) begin
            failures++;
            $display("FAIL wrap_pulse_spacing got=%0d exp=%0d", second - first, FRAME);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] got, exp;
        logic [63:0] f;
        logic [7:0]  sh_or;
        f = {$urandom, $urandom} | 64'h1;
        do_reset(f);
        // Row 5 drives during cycles 5*SLOT+BLANK .. 5*SLOT+SLOT-1. Reset is
        // asserted partway through that dwell.
        for (int c = 0; c <= 5 * SLOT + BLANK + 1; c++) q.push_back(model(c, f, 1'b1, 1'b0));
        q.push_back({8'hFF, 8'h00, 3'd0, 1'b0});
        for (int c = 1; c < 12; c++) q.push_back(model(c, f, 1'b1, 1'b0));
        for (int c = 0; c <= 5 * SLOT + BLANK + 1; c++) begin
            if (c > 0) @(negedge clk);
            exp = q.pop_front();
            got = {rowSel_a, colData_a, rowIdx_a, frameStart_a};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL midrst_pre c=%0d got=%h exp=%h", c, got, exp);
            end
        end
        rstBtn = 1'b1;
        @(negedge clk);
        exp = q.pop_front();
        got = {rowSel_a, colData_a, rowIdx_a, frameStart_a};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL midrst_state got=%h exp=%h", got, exp);
        end
        sh_or = 8'h00;
        for (int r = 0; r < 8; r++) sh_or = sh_or | dut_a.shadow[r];
        checks++;
        if (sh_or !== 8'h00) begin
            failures++;
            $display("FAIL midrst_shadow got=%h exp=00", sh_or);
        end
        rstBtn = 1'b0;
        for (int c = 1; c < 12; c++) begin
            @(negedge clk);
            exp = q.pop_front();
            got = {rowSel_a, colData_a, rowIdx_a, frameStart_a};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL midrst_post c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_polarity();
        logic [19:0] got, exp;
        logic [63:0] f;
        f = 64'h80;
        do_reset(f);
        for (int c = 0; c < 12; c++) q.push_back(model(c, f, 1'b0, 1'b1));
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            exp = q.pop_front();
            got = {rowSel_b, colData_b, rowIdx_b, frameStart_b};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL polarity c=%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tear();
        test_wrap();
        test_reset_mid();
        test_polarity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
